// File: rtl/matrix_host_port.sv
// Host-side front end for the matrix coprocessor: packs operands A and B into
// 256-bit RAM words, runs the coprocessor, and streams the result word back out.
module matrix_host_port #(
    parameter logic [7:0]  ADDR_A   = 8'd1,
    parameter logic [7:0]  ADDR_B   = 8'd2,
    parameter logic [7:0]  ADDR_C   = 8'd3,
    parameter int unsigned READ_LAT = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [7:0]   mem_address,
    output logic [255:0] mem_data,
    output logic         mem_wren,
    input  logic [255:0] mem_q,
    output logic         op_start,
    input  logic         op_done,
    output logic [7:0]   out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 256;
    localparam int unsigned CNT_W  = 5;
    localparam int unsigned RD_W   = $clog2(READ_LAT + 2);

    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(31);
    localparam logic [RD_W-1:0]  RD_LAST   = RD_W'(READ_LAT + 1);

    typedef enum logic [2:0] {
        ST_LOAD_A,
        ST_WR_A,
        ST_LOAD_B,
        ST_WR_B,
        ST_START,
        ST_WAIT,
        ST_RD,
        ST_UNPACK
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_inc;
    logic [RD_W-1:0]    rd_cnt;
    logic [WORD_W-1:0]  pack;
    logic [WORD_W-1:0]  unpack;
    logic               in_xfer;
    logic               out_xfer;

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;
    assign cnt_inc  = cnt + CNT_W'(1);

    // The pack register is the RAM write-data bus; it is only written in the load states.
    assign mem_data = pack;

    // Sequencer: load A, write A, load B, write B, start, wait, read, unpack.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ST_LOAD_A;
            cnt         <= '0;
            rd_cnt      <= '0;
            pack        <= '0;
            unpack      <= '0;
            in_ready    <= 1'b0;
            mem_address <= '0;
            mem_wren    <= 1'b0;
            op_start    <= 1'b0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                ST_LOAD_A, ST_LOAD_B: begin
                    in_ready <= 1'b1;
                    if (in_xfer) begin
                        pack[{cnt, 3'b000} +: BYTE_W] <= in_data;
                        busy <= 1'b1;
                        if (cnt == LAST_BYTE) begin
                            in_ready    <= 1'b0;
                            mem_wren    <= 1'b1;
                            mem_address <= (state == ST_LOAD_A) ? ADDR_A : ADDR_B;
                            state       <= (state == ST_LOAD_A) ? ST_WR_A : ST_WR_B;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                end

                ST_WR_A: begin
                    mem_wren <= 1'b0;
                    cnt      <= '0;
                    in_ready <= 1'b1;
                    state    <= ST_LOAD_B;
                end

                ST_WR_B: begin
                    mem_wren <= 1'b0;
                    cnt      <= '0;
                    state    <= ST_START;
                end

                ST_START: begin
                    op_start <= 1'b1;
                    state    <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (op_done) begin
                        op_start    <= 1'b0;
                        mem_address <= ADDR_C;
                        rd_cnt      <= '0;
                        state       <= ST_RD;
                    end
                end

                // Address is held stable, so mem_q is settled well before capture.
                ST_RD: begin
                    if (rd_cnt == RD_LAST) begin
                        unpack    <= mem_q;
                        out_data  <= mem_q[BYTE_W-1:0];
                        out_valid <= 1'b1;
                        cnt       <= '0;
                        state     <= ST_UNPACK;
                    end else begin
                        rd_cnt <= rd_cnt + RD_W'(1);
                    end
                end

                ST_UNPACK: begin
                    if (out_xfer) begin
                        if (cnt == LAST_BYTE) begin
                            out_valid <= 1'b0;
                            cnt       <= '0;
                            busy      <= 1'b0;
                            in_ready  <= 1'b1;
                            state     <= ST_LOAD_A;
                        end else begin
                            cnt      <= cnt_inc;
                            out_data <= unpack[{cnt_inc, 3'b000} +: BYTE_W];
                        end
                    end
                end

                default: begin
                    state <= ST_LOAD_A;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_host_port.sv
// Directed bench for matrix_host_port: operand loading, RAM writes, compute
// handshake, read latency, result streaming, mid-load reset and stalls.
module tb_matrix_host_port;

    logic         clk;
    logic         rst;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   mem_address;
    logic [255:0] mem_data;
    logic         mem_wren;
    logic [255:0] mem_q;
    logic         op_start;
    logic         op_done;
    logic [7:0]   out_data;
    logic         out_valid;
    logic         out_ready;
    logic         busy;

    int errors = 0;
    int checks = 0;
    int wr2_cnt = 0;

    matrix_host_port dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .mem_address (mem_address),
        .mem_data    (mem_data),
        .mem_wren    (mem_wren),
        .mem_q       (mem_q),
        .op_start    (op_start),
        .op_done     (op_done),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Writes to operand B's address, observed mid-cycle.
    always @(negedge clk) begin
        if (mem_wren === 1'b1 && mem_address === 8'd2) wr2_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_in_ready"},    256'(in_ready),    256'(0));
        check({tag, "_mem_wren"},    256'(mem_wren),    256'(0));
        check({tag, "_mem_address"}, 256'(mem_address), 256'(0));
        check({tag, "_mem_data"},    mem_data,          256'(0));
        check({tag, "_op_start"},    256'(op_start),    256'(0));
        check({tag, "_out_valid"},   256'(out_valid),   256'(0));
        check({tag, "_out_data"},    256'(out_data),    256'(0));
        check({tag, "_busy"},        256'(busy),        256'(0));
    endtask

    task automatic push(input logic [7:0] b);
        int guard;
        in_data  = b;
        in_valid = 1'b1;
        guard    = 0;
        while (in_ready !== 1'b1 && guard < 8) begin
            tick();
            guard++;
        end
        check("in_ready_wait", 256'(in_ready), 256'(1));
        tick();
        in_valid = 1'b0;
    endtask

    // Loads 32 bytes base..base+31 and checks the following write cycle.
    task automatic load_word(input logic [7:0] base, input logic [7:0] addr, input int done_at);
        logic [255:0] w;
        w = '0;
        for (int k = 0; k < 32; k++) begin
            w[k*8 +: 8] = 8'(base + 8'(k));
            if (k == done_at) begin
                op_done = 1'b1;
                tick();
                op_done = 1'b0;
                check("done_in_load_op_start", 256'(op_start), 256'(0));
                check("done_in_load_in_ready", 256'(in_ready), 256'(1));
                check("done_in_load_busy",     256'(busy),     256'(1));
                check("done_in_load_wren",     256'(mem_wren), 256'(0));
            end
            push(8'(base + 8'(k)));
        end
        check("wr_wren",     256'(mem_wren),    256'(1));
        check("wr_addr",     256'(mem_address), 256'(addr));
        check("wr_data",     mem_data,          w);
        check("wr_in_ready", 256'(in_ready),    256'(0));
        check("wr_busy",     256'(busy),        256'(1));
    endtask

    // Entered at the WR_B cycle; leaves on the first out_valid cycle.
    task automatic compute(input logic [255:0] word);
        tick();
        check("op_start_in_start", 256'(op_start), 256'(0));
        check("wren_after_wrb",    256'(mem_wren), 256'(0));
        tick();
        check("op_start_rise", 256'(op_start), 256'(1));
        for (int i = 0; i < 10; i++) begin
            tick();
            check("op_start_hold", 256'(op_start), 256'(1));
        end
        mem_q   = word;
        op_done = 1'b1;
        tick();
        op_done = 1'b0;
        check("op_start_fall", 256'(op_start),    256'(0));
        check("rd_addr",       256'(mem_address), 256'(3));
        check("rd_wren",       256'(mem_wren),    256'(0));
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("out_valid_early", 256'(out_valid), 256'(0));
        end
        tick();
        check("out_valid_first", 256'(out_valid), 256'(1));
        check("out_data_first",  256'(out_data),  256'(word[7:0]));
    endtask

    task automatic drain(input logic [255:0] word);
        int   k;
        int   guard;
        logic rdy;
        k     = 0;
        guard = 0;
        while (k < 32 && guard < 400) begin
            check("out_valid", 256'(out_valid), 256'(1));
            check("out_data",  256'(out_data),  256'(word[k*8 +: 8]));
            rdy       = 1'($urandom_range(0, 1));
            out_ready = rdy;
            tick();
            if (rdy) k++;
            guard++;
        end
        out_ready = 1'b0;
        check("out_count",     256'(k),         256'(32));
        check("out_valid_end", 256'(out_valid), 256'(0));
        check("busy_end",      256'(busy),      256'(0));
        check("in_ready_end",  256'(in_ready),  256'(1));
    endtask

    initial begin
        logic [255:0] w40;
        logic [255:0] wtog;
        int           k;
        int           cyc;
        int           wr2_before;

        rst       = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        mem_q     = '0;
        op_done   = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        check_reset("reset");
        rst = 1'b1;
        tick();
        check("in_ready_after_reset", 256'(in_ready), 256'(1));
        check("busy_idle",            256'(busy),     256'(0));

        // Transaction 1: A=00..1F, B=20..3F, result all ones.
        load_word(8'h00, 8'd1, -1);
        load_word(8'h20, 8'd2, -1);
        compute({256{1'b1}});
        drain({256{1'b1}});

        // Transaction 2: result bytes 40..5F, stray op_done in LOAD_A and UNPACK.
        for (int i = 0; i < 32; i++) w40[i*8 +: 8] = 8'(8'h40 + 8'(i));
        load_word(8'h80, 8'd1, 5);
        load_word(8'hA0, 8'd2, -1);
        compute(w40);
        out_ready = 1'b0;
        op_done   = 1'b1;
        tick();
        op_done = 1'b0;
        check("done_in_unpack_valid",    256'(out_valid),   256'(1));
        check("done_in_unpack_data",     256'(out_data),    256'(8'h40));
        check("done_in_unpack_op_start", 256'(op_start),    256'(0));
        check("done_in_unpack_addr",     256'(mem_address), 256'(3));
        drain(w40);

        // Load A with in_valid toggling every clock.
        wtog = '0;
        k    = 0;
        cyc  = 0;
        while (k < 32 && cyc < 200) begin
            in_valid = (cyc % 2 == 0);
            in_data  = in_valid ? 8'(8'h10 + 8'(k)) : 8'hEE;
            if (in_valid) begin
                check("tog_in_ready", 256'(in_ready), 256'(1));
                wtog[k*8 +: 8] = 8'(8'h10 + 8'(k));
            end
            tick();
            if (in_valid) k++;
            cyc++;
            if (k < 32) check("tog_no_early_write", 256'(mem_wren), 256'(0));
        end
        in_valid = 1'b0;
        check("tog_count", 256'(k),           256'(32));
        check("tog_wren",  256'(mem_wren),    256'(1));
        check("tog_addr",  256'(mem_address), 256'(1));
        check("tog_data",  mem_data,          wtog);

        // 17 bytes of B, then reset: no B write, reload A from scratch.
        wr2_before = wr2_cnt;
        for (int i = 0; i < 17; i++) push(8'(8'hC0 + 8'(i)));
        check("partial_b_busy", 256'(busy), 256'(1));
        rst = 1'b0;
        tick();
        check_reset("mid_reset");
        rst = 1'b1;
        tick();
        check("in_ready_after_mid_reset", 256'(in_ready), 256'(1));
        check("no_b_write", 256'(wr2_cnt), 256'(wr2_before));
        load_word(8'h60, 8'd1, -1);
        check("no_b_write_after_reload", 256'(wr2_cnt), 256'(wr2_before));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
